// File: rtl/imem_program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The master modport is the loader side; the slave modport is the host/memory side.
interface imem_program_loader_if #(
    parameter int ADDR_BITS = 8
);
    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [15:0]          mem_wdata;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/imem_program_loader.sv
// Loads a length-prefixed, checksummed byte frame into instruction memory as 16-bit words,
// holding the CPU until the image is verified. One write per DATA_LO byte, registered one cycle later.
module imem_program_loader #(
    parameter int ADDR_BITS = 8,
    parameter int WORD_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    imem_program_loader_if.master bus,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 error,
    output logic [ADDR_BITS:0]   words_written
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
    } state_t;

    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_BITS;

    state_t                 state_q, state_d;
    logic [7:0]             len_hi_q, len_hi_d;
    logic [ADDR_BITS:0]     len_q, len_d;
    logic [7:0]             hi_q, hi_d;
    logic [7:0]             sum_q, sum_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_BITS-1:0]   mem_wdata_q, mem_wdata_d;
    logic [ADDR_BITS:0]     ww_q, ww_d;

    logic                   in_ready;
    logic                   accept;
    logic [15:0]            n_full;
    logic [ADDR_BITS:0]     ww_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_hi_q    <= '0;
            len_q       <= '0;
            hi_q        <= '0;
            sum_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ww_q        <= '0;
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            len_q       <= len_d;
            hi_q        <= hi_d;
            sum_q       <= sum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ww_q        <= ww_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        len_d       = len_q;
        hi_d        = hi_q;
        sum_d       = sum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ww_d        = ww_q;

        in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA_HI)
                || (state_q == S_DATA_LO) || (state_q == S_CHECK);
        accept   = bus.in_valid && in_ready;
        n_full   = {len_hi_q, bus.in_data};
        ww_inc   = ww_q + 1'b1;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LEN_HI;
                    sum_d   = '0;
                    ww_d    = '0;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_hi_d = bus.in_data;
                    sum_d    = sum_q + bus.in_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    sum_d = sum_q + bus.in_data;
                    len_d = n_full[ADDR_BITS:0];
                    if ({1'b0, n_full} > CAPACITY) begin
                        state_d = S_ERROR;
                    end else if (n_full == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    hi_d    = bus.in_data;
                    sum_d   = sum_q + bus.in_data;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                // Write address is the pre-increment count, so word k lands at address k.
                if (accept) begin
                    sum_d       = sum_q + bus.in_data;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ww_q[ADDR_BITS-1:0];
                    mem_wdata_d = {hi_q, bus.in_data};
                    ww_d        = ww_inc;
                    state_d     = (ww_inc == len_q) ? S_CHECK : S_DATA_HI;
                end
            end
            S_CHECK: begin
                if (accept) begin
                    state_d = (bus.in_data == sum_q) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready   = in_ready;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign cpu_hold       = in_ready;
    assign done           = (state_q == S_DONE);
    assign error          = (state_q == S_ERROR);
    assign words_written  = ww_q;
endmodule

// File: tb/tb_imem_program_loader.sv
// Directed frame vectors plus hand-written multi-cycle sequences for the program loader (ADDR_BITS=4).
module tb_imem_program_loader;
    localparam int AB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          cpu_hold, done, error;
    logic [AB:0]   words_written;

    imem_program_loader_if #(.ADDR_BITS(AB)) bus ();

    imem_program_loader #(.ADDR_BITS(AB), .WORD_BITS(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .bus           (bus),
        .cpu_hold      (cpu_hold),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [AB-1:0] wr_addr [$];
    logic [15:0]   wr_data [$];

    always @(negedge clk) begin
        if (bus.mem_we) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_wdata);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called and returned on a falling edge; the byte transfers on the rising edge in between.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'hEE;
                @(negedge clk);
            end
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: in_ready stayed %b, required 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_mem_we"},   32'(bus.mem_we),   32'd0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_mem_wdata"},32'(bus.mem_wdata),32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold),     32'd0);
        chk({tag, "_done"},     32'(done),         32'd0);
        chk({tag, "_error"},    32'(error),        32'd0);
        chk({tag, "_ww"},       32'(words_written),32'd0);
    endtask

    typedef struct packed {
        logic [55:0] bytes;   // first byte in the top byte lane
        logic [3:0]  nb;
        logic        exp_done;
        logic        exp_err;
        logic [4:0]  exp_ww;
        logic [1:0]  nw;
        logic [31:0] words;   // {word0, word1}
    } vec_t;

    localparam logic [15:0] CASE1_W0 = 16'h1234;
    localparam logic [15:0] CASE1_W1 = 16'hABCD;

    initial begin
        vec_t        vecs [7];
        logic [7:0]  case1 [7];
        logic [7:0]  sum;
        logic [15:0] w16 [16];

        vecs[0] = '{56'h0002_1234_ABCD_C0, 4'd7, 1'b1, 1'b0, 5'd2, 2'd2, {CASE1_W0, CASE1_W1}};
        vecs[1] = '{56'h0002_1234_ABCD_C1, 4'd7, 1'b0, 1'b1, 5'd2, 2'd2, {CASE1_W0, CASE1_W1}};
        vecs[2] = '{56'h0011_0000_0000_00, 4'd2, 1'b0, 1'b1, 5'd0, 2'd0, 32'h0};
        vecs[3] = '{56'h0000_0000_0000_00, 4'd3, 1'b1, 1'b0, 5'd0, 2'd0, 32'h0};
        vecs[4] = '{56'h0001_FF01_0100_00, 4'd5, 1'b1, 1'b0, 5'd1, 2'd1, 32'hFF01_0000};
        vecs[5] = '{56'h0100_0000_0000_00, 4'd2, 1'b0, 1'b1, 5'd0, 2'd0, 32'h0};
        vecs[6] = '{56'h0001_0000_0200_00, 4'd5, 1'b0, 1'b1, 5'd1, 2'd1, 32'h0000_0000};
        case1   = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};

        reset = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Table-driven frames; each starts from IDLE, DONE or ERROR.
        for (int i = 0; i < 7; i++) begin
            wr_addr.delete();
            wr_data.delete();
            pulse_start();
            chk($sformatf("v%0d_hold_loading", i), 32'(cpu_hold), 32'd1);
            chk($sformatf("v%0d_ww_cleared", i), 32'(words_written), 32'd0);
            for (int k = 0; k < int'(vecs[i].nb); k++)
                send_byte(vecs[i].bytes[55 - 8*k -: 8], 1'b0);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_done", i),  32'(done),          32'(vecs[i].exp_done));
            chk($sformatf("v%0d_error", i), 32'(error),         32'(vecs[i].exp_err));
            chk($sformatf("v%0d_hold", i),  32'(cpu_hold),      32'd0);
            chk($sformatf("v%0d_ww", i),    32'(words_written), 32'(vecs[i].exp_ww));
            chk($sformatf("v%0d_nwr", i),   32'(wr_addr.size()),32'(vecs[i].nw));
            for (int k = 0; k < wr_addr.size() && k < int'(vecs[i].nw); k++) begin
                chk($sformatf("v%0d_addr%0d", i, k), 32'(wr_addr[k]), k);
                chk($sformatf("v%0d_data%0d", i, k), 32'(wr_data[k]), 32'(vecs[i].words[31 - 16*k -: 16]));
            end
        end

        // Full-capacity image: 16 words, last write at address F.
        wr_addr.delete();
        wr_data.delete();
        sum = 8'h10;
        for (int k = 0; k < 16; k++) begin
            w16[k] = {8'(k * 17), 8'(8'hA5 ^ 8'(k))};
            sum = sum + w16[k][15:8] + w16[k][7:0];
        end
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h10, 1'b0);
        for (int k = 0; k < 16; k++) begin
            send_byte(w16[k][15:8], 1'b0);
            send_byte(w16[k][7:0], 1'b0);
        end
        send_byte(sum, 1'b0);
        repeat (2) @(negedge clk);
        chk("full_done", 32'(done), 32'd1);
        chk("full_ww", 32'(words_written), 32'd16);
        chk("full_last_addr", 32'(bus.mem_addr), 32'hF);
        chk("full_nwr", 32'(wr_addr.size()), 32'd16);
        for (int k = 0; k < wr_addr.size() && k < 16; k++) begin
            chk($sformatf("full_addr%0d", k), 32'(wr_addr[k]), k);
            chk($sformatf("full_data%0d", k), 32'(wr_data[k]), 32'(w16[k]));
        end

        // in_valid while DONE is not accepted.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("done_ignore_ready", 32'(bus.in_ready), 32'd0);
        chk("done_ignore_done", 32'(done), 32'd1);
        chk("done_ignore_ww", 32'(words_written), 32'd16);

        // Case 1 with random valid gaps and start pulses mid-frame.
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        for (int k = 0; k < 7; k++) begin
            if (k == 3) start = 1'b1;
            send_byte(case1[k], 1'b1);
            start = 1'b0;
            if (k == 5) pulse_start();
        end
        repeat (2) @(negedge clk);
        chk("gaps_done", 32'(done), 32'd1);
        chk("gaps_error", 32'(error), 32'd0);
        chk("gaps_ww", 32'(words_written), 32'd2);
        chk("gaps_nwr", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            chk("gaps_w0", {16'(wr_addr[0]), wr_data[0]}, {16'd0, CASE1_W0});
            chk("gaps_w1", {16'(wr_addr[1]), wr_data[1]}, {16'd1, CASE1_W1});
        end

        // Reset right after the first DATA_LO byte, then a clean reload.
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        for (int k = 0; k < 4; k++) send_byte(case1[k], 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_idle_outputs("midreset");
        wr_addr.delete();
        wr_data.delete();
        repeat (3) @(negedge clk);
        chk("midreset_no_write", 32'(wr_addr.size()), 32'd0);
        pulse_start();
        for (int k = 0; k < 7; k++) send_byte(case1[k], 1'b0);
        repeat (2) @(negedge clk);
        chk("reload_done", 32'(done), 32'd1);
        chk("reload_nwr", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            chk("reload_w0", {16'(wr_addr[0]), wr_data[0]}, {16'd0, CASE1_W0});
            chk("reload_w1", {16'(wr_addr[1]), wr_data[1]}, {16'd1, CASE1_W1});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
